// File: rtl/frame_buf_mgr.sv
// frame_buf_mgr: N-buffer frame-store manager handing buffer index/base to writer and reader.
// Optional frame statistics counters are enabled by defining FRAME_BUF_MGR_STATS_EN.
module frame_buf_mgr #(
   parameter  int NUM_BUF     = 3,
   parameter  int ADDR_W      = 24,
   parameter  int FRAME_WORDS = 786432,
   parameter  int BASE_ADDR   = 0,
   parameter  int CNT_W       = 16,
   localparam int IDX_W       = (NUM_BUF > 2) ? $clog2(NUM_BUF) : 1
) (
   input  logic              clk,
   input  logic              rest_n,
   input  logic              wr_start,
   input  logic              wr_done,
   input  logic              rd_start,
   input  logic              freeze,
   output logic [IDX_W-1:0]  wr_idx,
   output logic [ADDR_W-1:0] wr_base,
   output logic [IDX_W-1:0]  rd_idx,
   output logic [ADDR_W-1:0] rd_base,
   output logic              wr_busy,
   output logic              new_frame,
   output logic [CNT_W-1:0]  drop_cnt,
   output logic [CNT_W-1:0]  wr_frame_cnt,
   output logic [CNT_W-1:0]  rd_frame_cnt
);

   localparam int SUM_W = ADDR_W + IDX_W;

   typedef enum logic {
      W_IDLE,
      W_ACTIVE
   } wstate_e;

   function automatic logic [ADDR_W-1:0] base_of(input logic [IDX_W-1:0] idx);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(BASE_ADDR) + SUM_W'(idx) * SUM_W'(FRAME_WORDS);
      return sum[ADDR_W-1:0];
   endfunction

   wstate_e           state_q, state_d;
   logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
   logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
   logic [IDX_W-1:0]  rdy_idx_q, rdy_idx_d;
   logic              rdy_valid_q, rdy_valid_d;
   logic              new_frame_q, new_frame_d;
   logic [ADDR_W-1:0] wr_base_q, wr_base_d;
   logic [ADDR_W-1:0] rd_base_q, rd_base_d;
   logic [CNT_W-1:0]  drop_q, drop_d;

   logic              done_acc;
   logic              excl_v;
   logic [IDX_W-1:0]  excl_idx;
   logic [IDX_W:0]    cand_w;
   logic [IDX_W-1:0]  cand;
   logic [IDX_W-1:0]  alloc_idx;
   logic              found;

   assign done_acc = (state_q == W_ACTIVE) && wr_done;

   // A frame completing this cycle supersedes the old ready frame, so only
   // the completing buffer needs protecting in that case.
   assign excl_v   = done_acc | rdy_valid_q;
   assign excl_idx = done_acc ? wr_idx_q : rdy_idx_q;

   always_comb begin
      alloc_idx = wr_idx_q;
      found     = 1'b0;
      cand_w    = '0;
      cand      = '0;
      for (int k = 1; k < NUM_BUF; k++) begin
         cand_w = {1'b0, wr_idx_q} + (IDX_W+1)'(k);
         if (cand_w >= (IDX_W+1)'(NUM_BUF)) begin
            cand_w = cand_w - (IDX_W+1)'(NUM_BUF);
         end
         cand = cand_w[IDX_W-1:0];
         if (!found && (cand != rd_idx_q) &&
             !(excl_v && (cand == excl_idx))) begin
            alloc_idx = cand;
            found     = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      wr_idx_d    = wr_idx_q;
      rd_idx_d    = rd_idx_q;
      rdy_idx_d   = rdy_idx_q;
      rdy_valid_d = rdy_valid_q;
      new_frame_d = 1'b0;
      drop_d      = drop_q;

      if (done_acc) begin
         state_d     = W_IDLE;
         rdy_idx_d   = wr_idx_q;
         rdy_valid_d = 1'b1;
         if (rdy_valid_q && (drop_q != '1)) begin
            drop_d = drop_q + CNT_W'(1);
         end
      end

      // Uses the post-completion ready slot so a coincident done is taken directly.
      if (rd_start && !freeze && rdy_valid_d) begin
         rd_idx_d    = rdy_idx_d;
         rdy_valid_d = 1'b0;
         new_frame_d = 1'b1;
      end

      if (wr_start && (state_d == W_IDLE)) begin
         state_d  = W_ACTIVE;
         wr_idx_d = alloc_idx;
      end

      wr_base_d = base_of(wr_idx_d);
      rd_base_d = base_of(rd_idx_d);
   end

   always_ff @(posedge clk) begin
      if (!rest_n) begin
         state_q     <= W_IDLE;
         wr_idx_q    <= IDX_W'(NUM_BUF - 1);
         rd_idx_q    <= '0;
         rdy_idx_q   <= '0;
         rdy_valid_q <= 1'b0;
         new_frame_q <= 1'b0;
         wr_base_q   <= base_of(IDX_W'(NUM_BUF - 1));
         rd_base_q   <= base_of('0);
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         wr_idx_q    <= wr_idx_d;
         rd_idx_q    <= rd_idx_d;
         rdy_idx_q   <= rdy_idx_d;
         rdy_valid_q <= rdy_valid_d;
         new_frame_q <= new_frame_d;
         wr_base_q   <= wr_base_d;
         rd_base_q   <= rd_base_d;
         drop_q      <= drop_d;
      end
   end

   assign wr_idx    = wr_idx_q;
   assign wr_base   = wr_base_q;
   assign rd_idx    = rd_idx_q;
   assign rd_base   = rd_base_q;
   assign wr_busy   = (state_q == W_ACTIVE);
   assign new_frame = new_frame_q;
   assign drop_cnt  = drop_q;

`ifdef FRAME_BUF_MGR_STATS_EN
   logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

   always_comb begin
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      if (done_acc) begin
         wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end
      if (rd_start) begin
         rd_cnt_d = rd_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rest_n) begin
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
      end
   end

   assign wr_frame_cnt = wr_cnt_q;
   assign rd_frame_cnt = rd_cnt_q;
`else
   assign wr_frame_cnt = '0;
   assign rd_frame_cnt = '0;
`endif

endmodule

// File: tb/tb_frame_buf_mgr.sv
// tb_frame_buf_mgr: random and directed stimulus for frame_buf_mgr,
// checked every cycle against a buffer-ownership model.
module tb_frame_buf_mgr;

   localparam int NB     = 3;
   localparam int FW     = 786432;
   localparam int B_BASE = 24'hF00000;

`ifdef FRAME_BUF_MGR_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rest_n   = 1'b0;
   logic wr_start = 1'b0;
   logic wr_done  = 1'b0;
   logic rd_start = 1'b0;
   logic freeze   = 1'b0;

   logic [1:0]  a_wr_idx, a_rd_idx, b_wr_idx, b_rd_idx;
   logic [23:0] a_wr_base, a_rd_base, b_wr_base, b_rd_base;
   logic        a_busy, a_nf, b_busy, b_nf;
   logic [15:0] a_drop, a_wrc, a_rdc;
   logic [3:0]  b_drop, b_wrc, b_rdc;

   frame_buf_mgr dut_a (
      .clk(clk), .rest_n(rest_n), .wr_start(wr_start), .wr_done(wr_done),
      .rd_start(rd_start), .freeze(freeze),
      .wr_idx(a_wr_idx), .wr_base(a_wr_base), .rd_idx(a_rd_idx), .rd_base(a_rd_base),
      .wr_busy(a_busy), .new_frame(a_nf), .drop_cnt(a_drop),
      .wr_frame_cnt(a_wrc), .rd_frame_cnt(a_rdc)
   );

   frame_buf_mgr #(.CNT_W(4), .BASE_ADDR(B_BASE)) dut_b (
      .clk(clk), .rest_n(rest_n), .wr_start(wr_start), .wr_done(wr_done),
      .rd_start(rd_start), .freeze(freeze),
      .wr_idx(b_wr_idx), .wr_base(b_wr_base), .rd_idx(b_rd_idx), .rd_base(b_rd_base),
      .wr_busy(b_busy), .new_frame(b_nf), .drop_cnt(b_drop),
      .wr_frame_cnt(b_wrc), .rd_frame_cnt(b_rdc)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mbase(input int idx, input int base);
      return (base + idx * FW) & 32'h00FF_FFFF;
   endfunction

   // Model: who owns which buffer (writer, display, ready slot) plus counters.
   int m_wr, m_rd, m_rdy;
   bit m_rdyv, m_act, m_nf;
   int m_drop, m_drop4, m_wrc, m_rdc;
   bit armed = 1'b0;

   always @(posedge clk) begin : model
      int ow, ord, ordy, c;
      bit ordv, done, taken;
      if (!rest_n) begin
         m_wr = NB - 1; m_rd = 0; m_rdy = 0;
         m_rdyv = 0; m_act = 0; m_nf = 0;
         m_drop = 0; m_drop4 = 0; m_wrc = 0; m_rdc = 0;
         armed = 1'b1;
      end else begin
         ow = m_wr; ord = m_rd; ordy = m_rdy; ordv = m_rdyv;
         done = m_act && wr_done;
         m_nf = 0;
         if (done) begin
            if (ordv) begin
               if (m_drop < 65535) m_drop++;
               if (m_drop4 < 15) m_drop4++;
            end
            m_rdy = ow; m_rdyv = 1; m_act = 0; m_wrc++;
         end
         if (rd_start) m_rdc++;
         if (rd_start && !freeze && m_rdyv) begin
            m_rd = m_rdy; m_rdyv = 0; m_nf = 1;
         end
         if (wr_start && !m_act) begin
            taken = 0;
            for (int k = 1; k < NB; k++) begin
               c = (ow + k) % NB;
               if (!taken && c != ord && !(!done && ordv && c == ordy)) begin
                  m_wr = c; taken = 1;
               end
            end
            m_act = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("a_wr_idx", a_wr_idx, m_wr);
         chk("a_wr_base", a_wr_base, mbase(m_wr, 0));
         chk("a_rd_idx", a_rd_idx, m_rd);
         chk("a_rd_base", a_rd_base, mbase(m_rd, 0));
         chk("a_busy", a_busy, m_act);
         chk("a_new_frame", a_nf, m_nf);
         chk("a_drop", a_drop, m_drop);
         chk("a_wrc", a_wrc, STATS ? (m_wrc & 'hFFFF) : 0);
         chk("a_rdc", a_rdc, STATS ? (m_rdc & 'hFFFF) : 0);
         chk("b_wr_idx", b_wr_idx, m_wr);
         chk("b_wr_base", b_wr_base, mbase(m_wr, B_BASE));
         chk("b_rd_idx", b_rd_idx, m_rd);
         chk("b_rd_base", b_rd_base, mbase(m_rd, B_BASE));
         chk("b_busy", b_busy, m_act);
         chk("b_new_frame", b_nf, m_nf);
         chk("b_drop", b_drop, m_drop4);
         chk("b_wrc", b_wrc, STATS ? (m_wrc & 'hF) : 0);
         chk("b_rdc", b_rdc, STATS ? (m_rdc & 'hF) : 0);
      end
   end

   task automatic drive(input bit rn, input bit ws, input bit wd,
                        input bit rs, input bit fz);
      @(negedge clk);
      rest_n = rn; wr_start = ws; wr_done = wd; rd_start = rs; freeze = fz;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
   endtask

   bit fz_r;

   initial begin
      // reset values
      do_reset();
      chk("lit_rst_wr_idx", a_wr_idx, 2);
      chk("lit_rst_wr_base", a_wr_base, 1572864);
      chk("lit_rst_rd_idx", a_rd_idx, 0);
      chk("lit_rst_rd_base", a_rd_base, 0);
      chk("lit_rst_busy", a_busy, 0);
      chk("lit_rst_nf", a_nf, 0);
      chk("lit_rst_drop", a_drop, 0);
      chk("lit_rst_b_wr_base", b_wr_base, 24'h080000);

      // single frame then display
      drive(1, 1, 0, 0, 0);
      chk("lit_s1_wr_idx", a_wr_idx, 1);
      chk("lit_s1_wr_base", a_wr_base, 786432);
      chk("lit_s1_busy", a_busy, 1);
      drive(1, 0, 1, 0, 0);
      chk("lit_s1_busy_done", a_busy, 0);
      drive(1, 0, 0, 1, 0);
      chk("lit_s1_rd_idx", a_rd_idx, 1);
      chk("lit_s1_rd_base", a_rd_base, 786432);
      chk("lit_s1_nf", a_nf, 1);
      drive(1, 0, 0, 0, 0);
      chk("lit_s1_nf_off", a_nf, 0);

      // two frames, no reader: one drop
      do_reset();
      drive(1, 1, 0, 0, 0);
      drive(1, 0, 1, 0, 0);
      drive(1, 1, 0, 0, 0);
      chk("lit_s2_wr_idx", a_wr_idx, 2);
      drive(1, 0, 1, 0, 0);
      chk("lit_s2_drop", a_drop, 1);
      drive(1, 0, 0, 1, 0);
      chk("lit_s2_rd_idx", a_rd_idx, 2);
      chk("lit_s2_nf", a_nf, 1);
      drive(1, 0, 0, 1, 0);
      chk("lit_s2_rd_idx2", a_rd_idx, 2);
      chk("lit_s2_nf2", a_nf, 0);

      // freeze
      do_reset();
      repeat (3) begin
         drive(1, 1, 0, 0, 1);
         drive(1, 0, 1, 0, 1);
         drive(1, 0, 0, 1, 1);
         chk("lit_fz_nf", a_nf, 0);
      end
      chk("lit_fz_rd_idx", a_rd_idx, 0);
      chk("lit_fz_drop", a_drop, 2);
      drive(1, 0, 0, 1, 0);
      chk("lit_fz_unfreeze_rd", a_rd_idx, 1);

      // done coincident with rd_start while a ready frame is pending
      drive(1, 1, 0, 0, 0);
      drive(1, 0, 1, 0, 0);
      drive(1, 1, 0, 0, 0);
      chk("lit_co_wr_idx", a_wr_idx, 0);
      drive(1, 0, 1, 1, 0);
      chk("lit_co_rd_idx", a_rd_idx, 0);
      chk("lit_co_drop", a_drop, 3);
      chk("lit_co_nf", a_nf, 1);
      drive(1, 0, 0, 1, 0);
      chk("lit_co_rd_idx2", a_rd_idx, 0);
      chk("lit_co_nf2", a_nf, 0);

      // reset mid-frame
      drive(1, 1, 0, 0, 0);
      chk("lit_mr_busy", a_busy, 1);
      drive(0, 0, 0, 0, 0);
      chk("lit_mr_wr_idx", a_wr_idx, 2);
      chk("lit_mr_rd_idx", a_rd_idx, 0);
      chk("lit_mr_busy0", a_busy, 0);
      chk("lit_mr_drop", a_drop, 0);
      drive(1, 0, 1, 0, 0);
      chk("lit_mr_done_ign", a_busy, 0);
      drive(1, 0, 0, 1, 0);
      chk("lit_mr_rd_hold", a_rd_idx, 0);
      chk("lit_mr_nf", a_nf, 0);

      // saturation and wrap
      do_reset();
      repeat (17) begin
         drive(1, 1, 0, 0, 1);
         drive(1, 0, 1, 0, 1);
      end
      chk("lit_sat_b_wrc", b_wrc, STATS ? 1 : 0);
      chk("lit_sat_b_drop16", b_drop, 15);
      chk("lit_sat_a_drop16", a_drop, 16);
      repeat (4) begin
         drive(1, 1, 0, 0, 1);
         drive(1, 0, 1, 0, 1);
      end
      chk("lit_sat_a_drop20", a_drop, 20);
      chk("lit_sat_b_drop20", b_drop, 15);

      // random traffic
      do_reset();
      fz_r = 0;
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 99) == 0) fz_r = ~fz_r;
         drive($urandom_range(0, 399) != 0,
               $urandom_range(0, 5) == 0,
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 6) == 0,
               fz_r);
      end
      drive(1, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/frame_buf_mgr.md
Name: frame_buf_mgr

Overview:
- Parametrised N-buffer frame-store manager in the sys_clk domain.
- Sits between the frame writer (camera side) and the frame reader (HDMI side). Hands each side a buffer index and SDRAM base address.
- Generalises the fixed triple-buffer occupy-block scheme:
  - configurable buffer count and frame size
  - round-robin write allocation
  - freeze (screenshot) mode
  - saturating dropped-frame counter

Parameters:
NUM_BUF, 3, number of frame buffers (legal 3..16)
ADDR_W, 24, SDRAM word-address width
FRAME_WORDS, 786432, words per frame buffer (1024x768x16bit)
BASE_ADDR, 0, word address of buffer 0
CNT_W, 16, width of statistics counters
(derived) IDX_W = max(1, clog2(NUM_BUF))

Ports:
clk  in  1  sys_clk; all logic on rising edge
rest_n  in  1  synchronous active-low reset
wr_start  in  1  1-cycle pulse: writer begins a new frame (already synchronised to clk)
wr_done  in  1  1-cycle pulse: writer finished the current frame
rd_start  in  1  1-cycle pulse: reader begins a new frame (vsync-derived)
freeze  in  1  level: hold displayed buffer
wr_idx  out  IDX_W  buffer the writer targets
wr_base  out  ADDR_W  BASE_ADDR + wr_idx*FRAME_WORDS
rd_idx  out  IDX_W  buffer the reader displays
rd_base  out  ADDR_W  BASE_ADDR + rd_idx*FRAME_WORDS
wr_busy  out  1  writer frame in progress
new_frame  out  1  1-cycle pulse: rd_idx switched to a fresh frame
drop_cnt  out  CNT_W  saturating count of completed frames never displayed
wr_frame_cnt  out  CNT_W  completed writes (see Optional Feature)
rd_frame_cnt  out  CNT_W  reader frame starts (see Optional Feature)

Behaviour:
- Reset is synchronous (rest_n low at a clk edge). It is valid mid-frame and abandons all state.
- Reset values:
  - rd_idx=0, rd_base=BASE_ADDR
  - wr_idx=NUM_BUF-1, wr_base=BASE_ADDR+(NUM_BUF-1)*FRAME_WORDS
  - wr_busy=0, new_frame=0, drop_cnt=0, counters=0
  - internal rdy_valid=0, rdy_idx=0
- All outputs are registered and change on the clk edge after the triggering pulse (latency 1). Base addresses are computed from the next-state index so idx and base are always coherent. Base arithmetic is computed at ADDR_W+IDX_W bits and truncated to ADDR_W.
- Writer FSM, W_IDLE / W_ACTIVE:
  - W_IDLE + wr_start -> W_ACTIVE, wr_busy=1. wr_idx = first index found searching cyclically from old wr_idx+1, skipping rd_idx and, if rdy_valid, rdy_idx. The search uses pre-edge register values. NUM_BUF>=3 guarantees a hit.
  - W_ACTIVE + wr_done -> W_IDLE, wr_busy=0. If rdy_valid was already 1, drop_cnt++. Then rdy_idx=wr_idx, rdy_valid=1.
  - W_ACTIVE + wr_start: restart the same buffer; wr_idx unchanged, no drop counted.
  - wr_done in W_IDLE: ignored.
  - wr_start and wr_done in the same cycle: wr_done processed first, then a new allocation made. The allocation excludes the just-completed buffer.
- Reader:
  - rd_start with rdy_valid=1 and freeze=0: rd_idx=rdy_idx, rdy_valid=0, new_frame=1 for one cycle.
  - Otherwise rd_idx is held and new_frame=0.
- freeze=1: reader never switches. The writer keeps cycling through the non-displayed buffers, and each overwritten ready frame increments drop_cnt.
- wr_done and rd_start in the same cycle (freeze=0): the reader takes the just-completed wr_idx directly and rdy_valid ends 0. A previously valid rdy frame counts as one drop.
- drop_cnt saturates at 2^CNT_W-1.

Optional Feature:
- Macro FRAME_BUF_MGR_STATS_EN.
- Defined: wr_frame_cnt increments on every accepted wr_done, and rd_frame_cnt on every rd_start. Both are free-running and wrap at 2^CNT_W.
- Undefined: both ports are still present and tied to 0, and no counter logic is synthesised.
- drop_cnt is always present.

Test Plan:
(All cases use defaults: NUM_BUF=3, FRAME_WORDS=786432, BASE_ADDR=0.)
- Reset -> wr_idx=2, wr_base=1572864, rd_idx=0, rd_base=0, wr_busy=0, new_frame=0, drop_cnt=0.
- wr_start -> next cycle wr_idx=1, wr_base=786432, wr_busy=1. Then wr_done -> wr_busy=0. Then rd_start -> rd_idx=1, rd_base=786432, one-cycle new_frame.
- Two complete write frames after reset, no rd_start -> frames land in idx 1 then 2, drop_cnt=1. Then rd_start -> rd_idx=2. A second rd_start gives no change and new_frame=0.
- freeze=1, three write frames, rd_start each frame -> rd_idx stays 0, drop_cnt=2, new_frame never. Then freeze=0 + rd_start -> rd_idx equals last written index.
- wr_done coincident with rd_start while rdy_valid=1 -> rd_idx=completing wr_idx, drop_cnt+1. A following rd_start leaves rd_idx unchanged.
- Second scenario:
  - rest_n low mid-frame (wr_busy=1) -> all reset values next edge, and a following wr_done is ignored.
  - With CNT_W=4, 20 drops -> drop_cnt=15.
  - With FRAME_BUF_MGR_STATS_EN, 17 wr_done -> wr_frame_cnt=1.
